// File: rtl/lap_timer_core.sv
// hh:mm:ss:cc up/down timer with sticky countdown expiry, validated preset load
// and a small lap-capture FIFO. Every output comes straight from a register.
module lap_timer_core #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int HOUR_MOD  = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_run_stop,
  input  logic                           i_clear,
  input  logic                           i_mode,
  input  logic                           i_load,
  input  logic [23:0]                    i_load_time,
  input  logic                           i_lap,
  input  logic                           i_lap_rd,
  output logic [23:0]                    o_time,
  output logic [23:0]                    o_lap_time,
  output logic                           o_lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_count,
  output logic                           o_lap_ovf,
  output logic                           o_expired,
  output logic                           o_wrap,
  output logic                           o_load_err
);

  localparam int TICK_N = CLK_HZ / 100;
  localparam int PW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam int AW     = $clog2(LAP_DEPTH);
  localparam int CW     = $clog2(LAP_DEPTH + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_N - 1);
  localparam logic [4:0]    HOUR_MAX  = 5'(HOUR_MOD - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(LAP_DEPTH);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic [6:0]    msec_q, msec_d;
  logic          expired_q, expired_d, wrap_q, wrap_d, load_err_q, load_err_d;

  logic [23:0]   mem_q [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, valid_q, valid_d;
  logic [23:0]   head_q, head_d;

  logic [23:0] time_q;
  logic [4:0]  ld_hour;
  logic [5:0]  ld_min, ld_sec;
  logic [6:0]  ld_msec;
  logic        load_ok, tick, time_zero;
  logic        push, pop, push_ok, full;

  assign time_q    = {hour_q, min_q, sec_q, msec_q};
  assign ld_hour   = i_load_time[23:19];
  assign ld_min    = i_load_time[18:13];
  assign ld_sec    = i_load_time[12:7];
  assign ld_msec   = i_load_time[6:0];
  assign load_ok   = (ld_msec <= 7'd99) && (ld_sec <= 6'd59) && (ld_min <= 6'd59) &&
                     ({1'b0, ld_hour} < 6'(HOUR_MOD));
  assign tick      = i_run_stop && !expired_q && (presc_q == PRESC_MAX);
  assign time_zero = (time_q == '0);

  // Time datapath: clear beats load beats tick; a rejected load lets counting carry on.
  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    msec_d     = msec_q;
    expired_d  = expired_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (i_clear) begin
      presc_d   = '0;
      hour_d    = '0;
      min_d     = '0;
      sec_d     = '0;
      msec_d    = '0;
      expired_d = 1'b0;
    end else if (i_load && load_ok) begin
      presc_d   = '0;
      hour_d    = ld_hour;
      min_d     = ld_min;
      sec_d     = ld_sec;
      msec_d    = ld_msec;
      expired_d = 1'b0;
    end else begin
      load_err_d = i_load;
      if (i_run_stop && !expired_q) presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && !i_mode) begin
        if (msec_q == 7'd99) begin
          msec_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d = '0;
              if (hour_q == HOUR_MAX) begin
                hour_d = '0;
                wrap_d = 1'b1;
              end else hour_d = hour_q + 5'd1;
            end else min_d = min_q + 6'd1;
          end else sec_d = sec_q + 6'd1;
        end else msec_d = msec_q + 7'd1;
      end else if (tick && i_mode) begin
        if (time_zero) begin
          expired_d = 1'b1;
        end else begin
          expired_d = (time_q == 24'd1);
          if (msec_q == 7'd0) begin
            msec_d = 7'd99;
            if (sec_q == 6'd0) begin
              sec_d = 6'd59;
              if (min_q == 6'd0) begin
                min_d  = 6'd59;
                hour_d = (hour_q == 5'd0) ? HOUR_MAX : hour_q - 5'd1;
              end else min_d = min_q - 6'd1;
            end else sec_d = sec_q - 6'd1;
          end else msec_d = msec_q - 7'd1;
        end
      end
    end
  end

  // Lap FIFO: a pop frees a slot the same cycle, so full+push+pop keeps the count.
  always_comb begin
    push     = i_lap && !i_clear;
    pop      = i_lap_rd && !i_clear && (count_q != '0);
    full     = (count_q == DEPTH_C);
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q || (push && full && !pop);
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      count_d  = '0;
    end
    valid_d = (count_d != '0);
    if (count_d == '0) head_d = '0;
    else if ((count_q == '0) || (pop && (count_q == CW'(1)))) head_d = time_q;
    else if (pop) head_d = mem_q[rd_ptr_q + AW'(1)];
    else head_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      msec_q     <= '0;
      expired_q  <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      msec_q     <= msec_d;
      expired_q  <= expired_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      if (push_ok) mem_q[wr_ptr_q] <= time_q;
    end
  end

  assign o_time      = time_q;
  assign o_lap_time  = head_q;
  assign o_lap_valid = valid_q;
  assign o_lap_count = count_q;
  assign o_lap_ovf   = ovf_q;
  assign o_expired   = expired_q;
  assign o_wrap      = wrap_q;
  assign o_load_err  = load_err_q;

endmodule

// File: tb/tb_lap_timer_core.sv
// Bench for lap_timer_core: centisecond-integer reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lap_timer_core;
  localparam int CLK_HZ    = 1000;
  localparam int HOUR_MOD  = 24;
  localparam int LAP_DEPTH = 4;
  localparam int TICK_N    = CLK_HZ / 100;
  localparam int DAY_CS    = HOUR_MOD * 360000;
  localparam int CW        = $clog2(LAP_DEPTH + 1);

  logic          clk;
  logic          reset_n, i_run_stop, i_clear, i_mode, i_load, i_lap, i_lap_rd;
  logic [23:0]   i_load_time;
  logic [23:0]   o_time, o_lap_time;
  logic          o_lap_valid, o_lap_ovf, o_expired, o_wrap, o_load_err;
  logic [CW-1:0] o_lap_count;

  int n_total = 0;
  int n_bad   = 0;

  lap_timer_core #(.CLK_HZ(CLK_HZ), .HOUR_MOD(HOUR_MOD), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_run_stop(i_run_stop), .i_clear(i_clear),
    .i_mode(i_mode), .i_load(i_load), .i_load_time(i_load_time), .i_lap(i_lap),
    .i_lap_rd(i_lap_rd), .o_time(o_time), .o_lap_time(o_lap_time),
    .o_lap_valid(o_lap_valid), .o_lap_count(o_lap_count), .o_lap_ovf(o_lap_ovf),
    .o_expired(o_expired), .o_wrap(o_wrap), .o_load_err(o_load_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] hmsc(input int h, input int m, input int s, input int c);
    return {h[4:0], m[5:0], s[5:0], c[6:0]};
  endfunction

  function automatic logic [23:0] pack_cs(input int t);
    return hmsc(t / 360000, (t / 6000) % 60, (t / 100) % 60, t % 100);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: time as total centiseconds, laps as a queue of those
  int m_t, m_presc;
  bit m_exp, m_wrap, m_lerr, m_ovf;
  int m_q[$];
  int t_old, lh, lm, ls, lc;
  bit pop_ok, load_acc;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_t = 0; m_presc = 0; m_exp = 0; m_wrap = 0; m_lerr = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      t_old  = m_t;
      m_wrap = 0;
      m_lerr = 0;
      if (i_clear) begin
        m_t = 0; m_presc = 0; m_exp = 0; m_ovf = 0;
        m_q.delete();
      end else begin
        pop_ok = i_lap_rd && (m_q.size() > 0);
        if (i_lap && m_q.size() == LAP_DEPTH && !pop_ok) m_ovf = 1;
        if (pop_ok) void'(m_q.pop_front());
        if (i_lap && m_q.size() < LAP_DEPTH) m_q.push_back(t_old);
        lh = int'(i_load_time[23:19]);
        lm = int'(i_load_time[18:13]);
        ls = int'(i_load_time[12:7]);
        lc = int'(i_load_time[6:0]);
        load_acc = i_load && lc <= 99 && ls <= 59 && lm <= 59 && lh < HOUR_MOD;
        if (load_acc) begin
          m_t = lh * 360000 + lm * 6000 + ls * 100 + lc;
          m_presc = 0;
          m_exp = 0;
        end else begin
          m_lerr = i_load;
          if (i_run_stop && !m_exp) begin
            if (m_presc == TICK_N - 1) begin
              m_presc = 0;
              if (!i_mode) begin
                if (m_t == DAY_CS - 1) m_wrap = 1;
                m_t = (m_t + 1) % DAY_CS;
              end else if (m_t == 0) begin
                m_exp = 1;
              end else begin
                m_t = m_t - 1;
                if (m_t == 0) m_exp = 1;
              end
            end else begin
              m_presc = m_presc + 1;
            end
          end
        end
      end
    end
  end

  // scoreboard compare, every cycle just after the edge
  always @(posedge clk) begin
    #1;
    check("time", o_time, pack_cs(m_t));
    check("expired", o_expired, m_exp);
    check("wrap", o_wrap, m_wrap);
    check("load_err", o_load_err, m_lerr);
    check("lap_ovf", o_lap_ovf, m_ovf);
    check("lap_count", o_lap_count, m_q.size());
    check("lap_valid", o_lap_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("lap_time", o_lap_time, pack_cs(m_q[0]));
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] v);
    @(negedge clk); i_load = 1'b1; i_load_time = v;
    @(negedge clk); i_load = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
  endtask

  task automatic do_lap();
    @(negedge clk); i_lap = 1'b1;
    @(negedge clk); i_lap = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk); i_lap_rd = 1'b1;
    @(negedge clk); i_lap_rd = 1'b0;
  endtask

  task automatic do_lap_pop();
    @(negedge clk); i_lap = 1'b1; i_lap_rd = 1'b1;
    @(negedge clk); i_lap = 1'b0; i_lap_rd = 1'b0;
  endtask

  logic [23:0] lap_v [5];

  initial begin
    reset_n = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0; i_mode = 1'b0;
    i_load = 1'b0; i_load_time = '0; i_lap = 1'b0; i_lap_rd = 1'b0;
    for (int k = 0; k < 5; k++) lap_v[k] = hmsc(1, k, 10 + k, 5 * k + 3);
    wait_clk(3);
    reset_n = 1'b1;
    check("rst_time", o_time, 24'd0);
    check("rst_valid", o_lap_valid, 1'b0);

    // 1: reset mid-count
    do_load(hmsc(0, 0, 5, 37));
    do_lap();
    i_run_stop = 1'b1;
    wait_clk(5);
    check("t1_pre_time", o_time, hmsc(0, 0, 5, 37));
    check("t1_pre_count", o_lap_count, 1);
    reset_n = 1'b0; i_run_stop = 1'b0;
    wait_clk(1);
    reset_n = 1'b1;
    check("t1_time", o_time, 24'd0);
    check("t1_count", o_lap_count, 0);
    check("t1_flags", {o_lap_valid, o_lap_ovf, o_expired, o_wrap, o_load_err}, 5'b0);

    // 2: up-count wrap
    i_mode = 1'b0;
    do_load(hmsc(23, 59, 59, 98));
    i_run_stop = 1'b1;
    wait_clk(10);
    check("t2_99", o_time, hmsc(23, 59, 59, 99));
    check("t2_nowrap", o_wrap, 1'b0);
    wait_clk(10);
    check("t2_zero", o_time, 24'd0);
    check("t2_wrap", o_wrap, 1'b1);
    i_run_stop = 1'b0;
    wait_clk(1);
    check("t2_wrap_end", o_wrap, 1'b0);

    // 3: countdown with sticky expiry
    i_mode = 1'b1;
    do_load(hmsc(0, 0, 1, 0));
    i_run_stop = 1'b1;
    wait_clk(10);
    check("t3_99", o_time, hmsc(0, 0, 0, 99));
    wait_clk(990);
    check("t3_zero", o_time, 24'd0);
    check("t3_exp", o_expired, 1'b1);
    wait_clk(100);
    check("t3_hold", o_time, 24'd0);
    check("t3_exp_hold", o_expired, 1'b1);
    i_run_stop = 1'b0;
    do_clear();
    check("t3_exp_clr", o_expired, 1'b0);
    i_run_stop = 1'b1;
    wait_clk(10);
    check("t3_exp_at0", o_expired, 1'b1);
    check("t3_time_at0", o_time, 24'd0);
    i_run_stop = 1'b0;
    do_clear();

    // 4: lap FIFO
    for (int k = 0; k < 5; k++) begin
      do_load(lap_v[k]);
      do_lap();
    end
    check("t4_count", o_lap_count, 4);
    check("t4_ovf", o_lap_ovf, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("t4_head", o_lap_time, lap_v[k]);
      do_pop();
    end
    check("t4_empty", o_lap_count, 0);
    check("t4_valid", o_lap_valid, 1'b0);
    do_pop();
    check("t4_pop_empty", o_lap_count, 0);
    do_clear();
    for (int k = 0; k < 4; k++) begin
      do_load(lap_v[k]);
      do_lap();
    end
    do_load(hmsc(2, 0, 0, 0));
    do_lap_pop();
    check("t4_fpp_count", o_lap_count, 4);
    check("t4_fpp_ovf", o_lap_ovf, 1'b0);
    check("t4_fpp_head", o_lap_time, lap_v[1]);

    // 5: rejected loads
    do_load(hmsc(0, 60, 0, 0));
    check("t5_err_min", o_load_err, 1'b1);
    check("t5_keep_min", o_time, hmsc(2, 0, 0, 0));
    wait_clk(1);
    check("t5_err_end", o_load_err, 1'b0);
    do_load(hmsc(24, 0, 0, 0));
    check("t5_err_hour", o_load_err, 1'b1);
    check("t5_keep_hour", o_time, hmsc(2, 0, 0, 0));
    do_load(hmsc(0, 0, 0, 100));
    check("t5_err_msec", o_load_err, 1'b1);
    do_load(hmsc(23, 59, 59, 99));
    check("t5_ok_err", o_load_err, 1'b0);
    check("t5_ok_time", o_time, hmsc(23, 59, 59, 99));

    // 6: prescaler hold across stop, then clear+load together
    do_clear();
    i_mode = 1'b0;
    i_run_stop = 1'b1;
    wait_clk(6);
    i_run_stop = 1'b0;
    wait_clk(5);
    i_run_stop = 1'b1;
    wait_clk(3);
    check("t6_before", o_time, 24'd0);
    wait_clk(1);
    check("t6_tick", o_time, hmsc(0, 0, 0, 1));
    @(negedge clk); i_clear = 1'b1; i_load = 1'b1; i_load_time = hmsc(5, 5, 5, 5);
    @(negedge clk); i_clear = 1'b0; i_load = 1'b0;
    check("t6_clr_ld", o_time, 24'd0);
    check("t6_clr_ld_err", o_load_err, 1'b0);
    i_run_stop = 1'b0;
    wait_clk(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
